// File: rtl/instr_loader.sv
// Instruction loader: receives a length-prefixed byte stream and writes
// 9-bit instruction words into an instruction memory, one word per WRITE cycle.
module instr_loader #(
  parameter int A = 10,  // instruction address width, depth 2**A (8..15)
  parameter int W = 9    // instruction word width, fixed at 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  output logic         wr_en,
  output logic [A-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
    DONE
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [A:0] MAX_WORDS = {1'b1, {A{1'b0}}};

  state_t     state, next_state;
  logic [7:0] len_lo;     // first length byte, held until LEN_HI arrives
  logic [A:0] n_words;    // session word count N
  logic [A:0] cnt;        // words written so far in this session (index k)
  logic [7:0] lo_q;       // low byte of the word being assembled

  logic [15:0] len16;
  logic [A:0]  n_calc;
  logic        len_bad;
  logic [A:0]  cnt_inc;
  logic        accept;

  // Length decode of the LEN_HI byte against the stored LEN_LO byte.
  assign len16   = {byte_data, len_lo};
  assign n_calc  = len16[A:0];
  assign len_bad = ((len16 >> (A + 1)) != 16'd0) || (n_calc > MAX_WORDS);
  assign cnt_inc = cnt + {{A{1'b0}}, 1'b1};
  assign accept  = byte_valid && byte_ready;

  // State register; synchronous reset aborts any session in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and Moore outputs derived from the current state.
  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    next_state = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) next_state = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (accept) next_state = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (accept) begin
          if (len_bad || (n_calc == '0)) next_state = DONE;
          else                           next_state = DATA_LO;
        end
      end
      DATA_LO: begin
        byte_ready = 1'b1;
        if (accept) next_state = DATA_HI;
      end
      DATA_HI: begin
        byte_ready = 1'b1;
        if (accept) next_state = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (cnt_inc < n_words) next_state = DATA_LO;
        else                   next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) next_state = LEN_LO;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, write address/data and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_lo  <= '0;
      n_words <= '0;
      cnt     <= '0;
      lo_q    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt <= '0;
            err <= 1'b0;
          end
        end
        LEN_LO: begin
          if (byte_valid) len_lo <= byte_data;
        end
        LEN_HI: begin
          if (byte_valid) begin
            n_words <= n_calc;
            if (len_bad) err <= 1'b1;
          end
        end
        DATA_LO: begin
          if (byte_valid) lo_q <= byte_data;
        end
        DATA_HI: begin
          // Word is presented during the following WRITE cycle and held after.
          if (byte_valid) begin
            wr_addr <= cnt[A-1:0];
            wr_data <= {byte_data[0], lo_q};
            if (byte_data[7:1] != 7'd0) err <= 1'b1;
          end
        end
        WRITE: begin
          cnt <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_instr_loader;

  localparam int A = 10;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_data = 8'h00;
  logic         byte_ready;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;
  int wcount   = 0;   // wr_en pulses seen since time 0
  int w0;

  instr_loader #(.A(A), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Count write strobes, sampled mid-cycle.
  always @(negedge clk) if (wr_en === 1'b1) wcount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks begin and end just after a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte until it is accepted; optional idle gap first.
  task automatic send(input logic [7:0] b, input bit gap);
    int guard;
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (byte_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: byte_ready never rose for byte %0h", b);
    end
    @(negedge clk);
    if (gap) byte_valid = 1'b0;
  endtask

  // Send one word and verify the write cycle immediately after the high byte.
  task automatic send_word(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                           input int addr, input bit gap);
    send(lo, gap);
    send(hi, gap);
    check({tag, "_wr_en"}, wr_en, 1);
    check({tag, "_addr"}, wr_addr, addr);
    check({tag, "_data"}, wr_data, {hi[0], lo});
    check({tag, "_ready"}, byte_ready, 0);
  endtask

  task automatic idle_bus();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", byte_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", byte_ready, 0);

    // Three words, continuous stream
    pulse_start();
    check("len_ready", byte_ready, 1);
    w0 = wcount;
    send(8'h03, 0);
    send(8'h00, 0);
    send_word("c0", 8'h12, 8'h01, 0, 0);
    send_word("c1", 8'h34, 8'h00, 1, 0);
    send_word("c2", 8'hFF, 8'h01, 2, 0);
    idle_bus();
    @(negedge clk);
    check("c_done", done, 1);
    check("c_err", err, 0);
    check("c_nwrites", wcount - w0, 3);
    check("c_done_ready", byte_ready, 0);

    // Zero-length session restarted from DONE
    w0 = wcount;
    pulse_start();
    check("z_done_clr", done, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    idle_bus();
    check("z_done", done, 1);
    check("z_err", err, 0);
    repeat (2) @(negedge clk);
    check("z_nwrites", wcount - w0, 0);

    // Oversized length: N = 1025
    w0 = wcount;
    pulse_start();
    send(8'h01, 0);
    send(8'h04, 0);
    idle_bus();
    check("big_done", done, 1);
    check("big_err", err, 1);
    check("big_ready", byte_ready, 0);
    // byte_valid in DONE must have no effect
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) @(negedge clk);
    idle_bus();
    check("big_nwrites", wcount - w0, 0);
    check("big_hold", done, 1);

    // Toggled byte_valid: same writes as continuous, delayed; start clears err
    w0 = wcount;
    pulse_start();
    check("t_err_clr", err, 0);
    // start while loading must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t_ign_start", byte_ready, 1);
    send(8'h02, 1);
    send(8'h00, 1);
    // stall in DATA_LO for a few cycles
    repeat (4) @(negedge clk);
    check("t_stall_ready", byte_ready, 1);
    check("t_stall_nw", wcount - w0, 0);
    send_word("t0", 8'h12, 8'h01, 0, 1);
    send_word("t1", 8'h34, 8'h00, 1, 1);
    @(negedge clk);
    check("t_done", done, 1);
    check("t_err", err, 0);
    check("t_nwrites", wcount - w0, 2);
    check("t_hold_addr", wr_addr, 1);
    check("t_hold_data", wr_data, 9'h034);

    // Bad high byte: word still written, err sticky
    pulse_start();
    send(8'h02, 0);
    send(8'h00, 0);
    send_word("e0", 8'h55, 8'h03, 0, 0);
    check("e_err_w0", err, 1);
    send_word("e1", 8'h0A, 8'h00, 1, 0);
    idle_bus();
    @(negedge clk);
    check("e_done", done, 1);
    check("e_err_done", err, 1);
    pulse_start();
    check("e_err_clr", err, 0);
    check("e_done_clr", done, 0);

    // Reset mid-session after two words of four
    do_reset();
    w0 = wcount;
    pulse_start();
    send(8'h04, 0);
    send(8'h00, 0);
    send_word("r0", 8'h11, 8'h00, 0, 0);
    send_word("r1", 8'h22, 8'h01, 1, 0);
    rst_n = 1'b0;
    start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h33;
    @(negedge clk);
    check("r_wr_en", wr_en, 0);
    check("r_addr", wr_addr, 0);
    check("r_data", wr_data, 0);
    check("r_done", done, 0);
    check("r_err", err, 0);
    check("r_ready", byte_ready, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    idle_bus();
    check("r_nwrites", wcount - w0, 2);
    pulse_start();
    send(8'h01, 0);
    send(8'h00, 0);
    send_word("n0", 8'h77, 8'h01, 0, 0);
    idle_bus();
    @(negedge clk);
    check("n_done", done, 1);
    check("n_err", err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Overall time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
